// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip8_pkg
// Brief    : Op codes, blitter state encoding and default screen geometry
//            shared by the CHIP-8 blitter and its row-merge datapath.
// Revision : 1.0 - initial release
// ============================================================================
package chip8_pkg;

    localparam logic CHIP8_OP_DRAW  = 1'b0;
    localparam logic CHIP8_OP_CLEAR = 1'b1;

    localparam int CHIP8_SCREEN_W = 64;
    localparam int CHIP8_SCREEN_H = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5
    } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/chip8_row_merge.sv
`default_nettype none
// ============================================================================
// Module   : chip8_row_merge
// Brief    : XORs one sprite byte into a display row at column x0 and flags
//            any pixel that was turned off. Edge columns wrap when
//            CHIP8_BLIT_WRAP_EN is defined, otherwise they are clipped.
// Revision : 1.0 - initial release
// ============================================================================
module chip8_row_merge
    import chip8_pkg::*;
#(
    parameter int   SCREEN_W = CHIP8_SCREEN_W,
    localparam int  XW       = $clog2(SCREEN_W)
) (
    input  logic [SCREEN_W-1:0] old_row,
    input  logic [7:0]          sprite,
    input  logic [XW-1:0]       x0,
    output logic [SCREEN_W-1:0] new_row,
    output logic                collide
);

    logic [7:0]          sprite_rev;
    logic [SCREEN_W-1:0] mask;

    // Sprite MSB is the leftmost pixel, i.e. the lowest column index.
    for (genvar i = 0; i < 8; i++) begin : g_rev
        assign sprite_rev[i] = sprite[7-i];
    end

`ifdef CHIP8_BLIT_WRAP_EN
    logic [2*SCREEN_W-1:0] shifted;

    assign shifted = {{(2*SCREEN_W-8){1'b0}}, sprite_rev} << x0;
    assign mask    = shifted[SCREEN_W-1:0] | shifted[2*SCREEN_W-1:SCREEN_W];
`else
    assign mask    = {{(SCREEN_W-8){1'b0}}, sprite_rev} << x0;
`endif

    assign new_row = old_row ^ mask;
    assign collide = |(old_row & mask);

endmodule
`default_nettype wire

// File: rtl/chip8_blitter.sv
`default_nettype none
// ============================================================================
// Module   : chip8_blitter
// Brief    : DXYN / 00E0 engine: reads sprite bytes, XOR-merges them into
//            VRAM rows and reports VF. Define CHIP8_BLIT_WRAP_EN for
//            wrap-around edges; the default build clips.
// Revision : 1.0 - initial release
// ============================================================================
module chip8_blitter
    import chip8_pkg::*;
#(
    parameter int SCREEN_W = CHIP8_SCREEN_W,
    parameter int SCREEN_H = CHIP8_SCREEN_H,
    parameter int MEM_LAT  = 2,
    parameter int ROW_W    = $clog2(SCREEN_H)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [7:0]          cmd_x,
    input  logic [7:0]          cmd_y,
    input  logic [3:0]          cmd_n,
    input  logic [11:0]         cmd_addr,
    output logic                done,
    output logic                collision,
    output logic [11:0]         ram_address_out,
    input  logic [7:0]          ram_data_in,
    output logic [ROW_W-1:0]    vram_address_out,
    input  logic [SCREEN_W-1:0] vram_data_in,
    output logic [SCREEN_W-1:0] vram_data_out,
    output logic                vram_write
);

    localparam int XW  = $clog2(SCREEN_W);
    localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    blit_state_t         state, state_next;
    logic [XW-1:0]       x0;
    logic [ROW_W-1:0]    y0;
    logic [3:0]          n;
    logic [11:0]         addr;
    logic [3:0]          r;
    logic [WCW-1:0]      wait_cnt;

    logic                accept;
    logic [3:0]          r_next;
    logic                wait_last;
    logic                off_screen;
    int                  row_sum;
    logic [ROW_W-1:0]    issue_row;
    logic [11:0]         issue_addr;
    logic [SCREEN_W-1:0] merged_row;
    logic                merge_collide;

    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign done      = (state == ST_DONE) && !reset;

    chip8_row_merge #(
        .SCREEN_W (SCREEN_W)
    ) u_merge (
        .old_row (vram_data_in),
        .sprite  (ram_data_in),
        .x0      (x0),
        .new_row (merged_row),
        .collide (merge_collide)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept    = cmd_valid && (state == ST_IDLE);
        r_next    = r + 4'd1;
        wait_last = (wait_cnt == WCW'(MEM_LAT - 1));
        // Address of the row about to be issued: first row on accept, else the next one.
        if (state == ST_IDLE) begin
            row_sum    = int'(cmd_y) % SCREEN_H;
            issue_addr = cmd_addr;
        end else begin
            row_sum    = int'(y0) + int'(r_next);
            issue_addr = addr + 12'(r_next);
        end
        issue_row = ROW_W'(row_sum % SCREEN_H);
`ifdef CHIP8_BLIT_WRAP_EN
        off_screen = 1'b0;
`else
        off_screen = (row_sum >= SCREEN_H);
`endif

        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == CHIP8_OP_CLEAR) begin
                        state_next = ST_CLEAR;
                    end else if (cmd_n == 4'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (wait_last) state_next = ST_WRITE;
            ST_WRITE: state_next = ((r_next == n) || off_screen) ? ST_DONE : ST_ISSUE;
            ST_CLEAR: if (vram_address_out == ROW_W'(SCREEN_H - 1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x0               <= '0;
            y0               <= '0;
            n                <= '0;
            addr             <= '0;
            r                <= '0;
            wait_cnt         <= '0;
            collision        <= 1'b0;
            ram_address_out  <= '0;
            vram_address_out <= '0;
            vram_data_out    <= '0;
            vram_write       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x0        <= XW'(int'(cmd_x) % SCREEN_W);
                        y0        <= ROW_W'(int'(cmd_y) % SCREEN_H);
                        n         <= cmd_n;
                        addr      <= cmd_addr;
                        r         <= '0;
                        collision <= 1'b0;
                        if (cmd_op == CHIP8_OP_CLEAR) begin
                            vram_address_out <= '0;
                            vram_data_out    <= '0;
                            vram_write       <= 1'b1;
                        end else if (cmd_n != 4'd0) begin
                            ram_address_out  <= issue_addr;
                            vram_address_out <= issue_row;
                        end
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + WCW'(1);
                    // Both memories deliver in the last wait cycle; register the merged row.
                    if (wait_last) begin
                        vram_data_out <= merged_row;
                        vram_write    <= 1'b1;
                        collision     <= collision | merge_collide;
                    end
                end
                ST_WRITE: begin
                    vram_write <= 1'b0;
                    r          <= r_next;
                    if (state_next == ST_ISSUE) begin
                        ram_address_out  <= issue_addr;
                        vram_address_out <= issue_row;
                    end
                end
                ST_CLEAR: begin
                    if (state_next == ST_DONE) begin
                        vram_write <= 1'b0;
                    end else begin
                        vram_address_out <= vram_address_out + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_blitter
// Brief    : Directed self-checking bench for chip8_blitter (64x32, latency 2)
//            with behavioural RAM/VRAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_blitter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_addr;
    logic        done;
    logic        collision;
    logic [11:0] ram_address_out;
    logic [7:0]  ram_data_in;
    logic [4:0]  vram_address_out;
    logic [63:0] vram_data_in;
    logic [63:0] vram_data_out;
    logic        vram_write;

    logic [7:0]  ram  [0:4095];
    logic [63:0] vram [0:31];
    logic [11:0] ram_p0, ram_p1;
    logic [4:0]  vram_p0, vram_p1;
    logic        mem_clr;

    int          wr_count = 0;
    int          wr_row [0:255];
    logic [63:0] wr_dat [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chip8_blitter #(
        .SCREEN_W (64),
        .SCREEN_H (32),
        .MEM_LAT  (LAT)
    ) dut (
        .clock            (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_x            (cmd_x),
        .cmd_y            (cmd_y),
        .cmd_n            (cmd_n),
        .cmd_addr         (cmd_addr),
        .done             (done),
        .collision        (collision),
        .ram_address_out  (ram_address_out),
        .ram_data_in      (ram_data_in),
        .vram_address_out (vram_address_out),
        .vram_data_in     (vram_data_in),
        .vram_data_out    (vram_data_out),
        .vram_write       (vram_write)
    );

    // Two-stage address pipeline gives data LAT cycles after the address.
    assign ram_data_in  = ram[ram_p1];
    assign vram_data_in = vram[vram_p1];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) vram[i] <= '0;
            ram_p0  <= '0;
            ram_p1  <= '0;
            vram_p0 <= '0;
            vram_p1 <= '0;
        end else begin
            ram_p0  <= ram_address_out;
            ram_p1  <= ram_p0;
            vram_p0 <= vram_address_out;
            vram_p1 <= vram_p0;
            if (vram_write) begin
                vram[vram_address_out] <= vram_data_out;
                if (wr_count < 256) begin
                    wr_row[wr_count] <= int'(vram_address_out);
                    wr_dat[wr_count] <= vram_data_out;
                end
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic op, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] nrows,
                           input logic [11:0] a, output int cycles,
                           output logic coll, output int base);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        base      = wr_count;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_n     = nrows;
        cmd_addr  = a;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cycles    = 1;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
        coll = collision;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_clear(input string tag);
        int    cyc, base, bad_order, bad_data;
        logic  coll;
        logic [63:0] acc;
        run_cmd(tag, 1'b1, 8'd0, 8'd0, 4'd0, 12'd0, cyc, coll, base);
        bad_order = 0;
        bad_data  = 0;
        for (int i = 0; i < 32; i++) begin
            if (wr_row[base + i] != i) bad_order++;
            if (wr_dat[base + i] != 64'd0) bad_data++;
        end
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | vram[i];
        check({tag, "_writes"}, 64'(wr_count - base), 64'd32);
        check({tag, "_order"}, 64'(bad_order), 64'd0);
        check({tag, "_wdata"}, 64'(bad_data), 64'd0);
        check({tag, "_cycles"}, 64'(cyc), 64'd33);
        check({tag, "_coll"}, 64'(coll), 64'd0);
        check({tag, "_vram_zero"}, acc, 64'd0);
    endtask

    int   cyc, base, t;
    logic coll;

    initial begin
        reset     = 1'b1;
        mem_clr   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_n     = '0;
        cmd_addr  = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'hF0;
        ram[12'h210] = 8'hFF;
        for (int i = 0; i < 4; i++) ram[12'h220 + i] = 8'h80;
        ram[12'h230] = 8'hA5;
        for (int i = 0; i < 5; i++) ram[12'h240 + i] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_coll", 64'(collision), 64'd0);
        check("rst_vwrite", 64'(vram_write), 64'd0);
        check("rst_raddr", 64'(ram_address_out), 64'd0);
        check("rst_vaddr", 64'(vram_address_out), 64'd0);
        check("rst_vdata", vram_data_out, 64'd0);
        mem_clr = 1'b0;
        reset   = 1'b0;
        #1;
        check("rel_ready", 64'(cmd_ready), 64'd1);

        check_clear("clr1");

        run_cmd("draw_f0", 1'b0, 8'd0, 8'd0, 4'd1, 12'h200, cyc, coll, base);
        check("draw_f0_row0", vram[0], 64'h0000_0000_0000_000F);
        check("draw_f0_coll", 64'(coll), 64'd0);
        check("draw_f0_cycles", 64'(cyc), 64'd5);
        run_cmd("redraw_f0", 1'b0, 8'd0, 8'd0, 4'd1, 12'h200, cyc, coll, base);
        check("redraw_f0_row0", vram[0], 64'd0);
        check("redraw_f0_coll", 64'(coll), 64'd1);
        check("redraw_f0_cycles", 64'(cyc), 64'd5);

        run_cmd("edge_x", 1'b0, 8'd62, 8'd0, 4'd1, 12'h210, cyc, coll, base);
`ifdef CHIP8_BLIT_WRAP_EN
        check("edge_x_row0", vram[0], 64'hC000_0000_0000_003F);
`else
        check("edge_x_row0", vram[0], 64'hC000_0000_0000_0000);
`endif
        check("edge_x_coll", 64'(coll), 64'd0);
        check("edge_x_writes", 64'(wr_count - base), 64'd1);

        check_clear("clr2");

        run_cmd("edge_y", 1'b0, 8'd0, 8'd30, 4'd4, 12'h220, cyc, coll, base);
`ifdef CHIP8_BLIT_WRAP_EN
        check("edge_y_writes", 64'(wr_count - base), 64'd4);
        check("edge_y_cycles", 64'(cyc), 64'd17);
        check("edge_y_w2", 64'(wr_row[base + 2]), 64'd0);
        check("edge_y_w3", 64'(wr_row[base + 3]), 64'd1);
        check("edge_y_row0", vram[0], 64'd1);
        check("edge_y_row1", vram[1], 64'd1);
`else
        check("edge_y_writes", 64'(wr_count - base), 64'd2);
        check("edge_y_cycles", 64'(cyc), 64'd9);
        check("edge_y_row0", vram[0], 64'd0);
`endif
        check("edge_y_w0", 64'(wr_row[base]), 64'd30);
        check("edge_y_w1", 64'(wr_row[base + 1]), 64'd31);
        check("edge_y_row30", vram[30], 64'd1);
        check("edge_y_row31", vram[31], 64'd1);

        check_clear("clr3");

        run_cmd("mod_xy", 1'b0, 8'd70, 8'd33, 4'd1, 12'h230, cyc, coll, base);
        check("mod_xy_wrow", 64'(wr_row[base]), 64'd1);
        check("mod_xy_row1", vram[1], 64'h0000_0000_0000_2940);
        check("mod_xy_coll", 64'(coll), 64'd0);
        run_cmd("mod_xy2", 1'b0, 8'd70, 8'd33, 4'd1, 12'h230, cyc, coll, base);
        check("mod_xy2_row1", vram[1], 64'd0);
        check("mod_xy2_coll", 64'(coll), 64'd1);

        run_cmd("n0", 1'b0, 8'd5, 8'd5, 4'd0, 12'h200, cyc, coll, base);
        check("n0_cycles", 64'(cyc), 64'd1);
        check("n0_writes", 64'(wr_count - base), 64'd0);
        check("n0_coll", 64'(coll), 64'd0);

        // Reset once the first of five rows has been written.
        check("mid_ready", 64'(cmd_ready), 64'd1);
        base      = wr_count;
        cmd_op    = 1'b0;
        cmd_x     = 8'd0;
        cmd_y     = 8'd10;
        cmd_n     = 4'd5;
        cmd_addr  = 12'h240;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (wr_count == base && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("mid_first_row", 64'(wr_count - base), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_vwrite", 64'(vram_write), 64'd0);
        check("mid_ready_rst", 64'(cmd_ready), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        reset = 1'b0;
        #1;
        check("mid_ready_rel", 64'(cmd_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("mid_writes", 64'(wr_count - base), 64'd1);
        check("mid_row10", vram[10], 64'h0000_0000_0000_00FF);
        check("mid_row11", vram[11], 64'd0);

        run_cmd("post", 1'b0, 8'd0, 8'd11, 4'd1, 12'h200, cyc, coll, base);
        check("post_row11", vram[11], 64'h0000_0000_0000_000F);
        check("post_coll", 64'(coll), 64'd0);
        check("post_cycles", 64'(cyc), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chip8_blitter.md
# chip8_blitter

Parametrised sprite/clear engine for the CHIP-8 display path. It takes DXYN and 00E0 requests from the CPU core over a valid/ready handshake. It reads sprite bytes from program RAM and read-modify-writes display rows in VRAM using XOR. It reports the VF collision flag. It generalises screen size (64x32 CHIP-8, 128x64 SCHIP) and memory latency. Edge handling is selectable between clip and wrap.

## Interface
Parameters:
- SCREEN_W, 64: pixels per row; also the VRAM word width.
- SCREEN_H, 32: rows; VRAM depth.
- MEM_LAT, 2: read latency in cycles, shared by RAM and VRAM. Must be ≥1.
- ROW_W, $clog2(SCREEN_H): VRAM address width (derived).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  request present
- cmd_ready  out  1  engine idle; request accepted when valid && ready
- cmd_op  in  1  0 = draw (DXYN), 1 = clear (00E0)
- cmd_x  in  8  VX value
- cmd_y  in  8  VY value
- cmd_n  in  4  sprite rows N
- cmd_addr  in  12  register I
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid with done, held until next accept
- ram_address_out  out  12  sprite byte address
- ram_data_in  in  8  sprite byte, MEM_LAT cycles after address
- vram_address_out  out  ROW_W  row index
- vram_data_in  in  SCREEN_W  row data, MEM_LAT cycles after address
- vram_data_out  out  SCREEN_W  row write data
- vram_write  out  1  row write strobe

## Operation
- States are IDLE, ISSUE, WAIT, WRITE, CLEAR and DONE.
- IDLE: cmd_ready=1. On accept, the engine latches all cmd_* fields.
  - It computes x0 = cmd_x mod SCREEN_W and y0 = cmd_y mod SCREEN_H. The start point always wraps.
  - It clears collision and the row counter r.
  - Draw with N=0 goes directly to DONE with collision=0.
  - Clear goes to CLEAR.
- ISSUE: row = y0 + r. ram_address_out = cmd_addr + r, truncated to 12 bits. vram_address_out = row. Then go to WAIT.
- WAIT: hold both addresses for MEM_LAT cycles, then go to WRITE.
- WRITE:
  - mask bit (x0+i) = ram_data_in[7-i] for i=0..7.
  - vram_data_out = vram_data_in XOR mask.
  - collision |= |(vram_data_in & mask).
  - vram_write=1 for exactly this cycle.
  - Then r++. If r == N, or the next row is off-screen in clip mode, go to DONE. Otherwise go to ISSUE.
- CLEAR: vram_write=1 and vram_data_out=0 for rows 0..SCREEN_H-1, one row per cycle in ascending order. Then go to DONE. collision stays 0.
- DONE: done=1 for one cycle, then return to IDLE.
- Requests presented while busy are not accepted; there is no queueing.
- Reset mid-operation: the engine returns to IDLE at the next edge with vram_write=0. A partially drawn sprite remains in VRAM.
- Reset values: cmd_ready=0 while reset is high, done=0, collision=0, vram_write=0. All address and data outputs are 0.

## Timing
- cmd_ready = (state==IDLE) && !reset. It is high in the first cycle after reset deasserts.
- Draw of N visible rows: done rises N·(MEM_LAT+2)+1 cycles after the accept edge.
- Each visible row takes one ISSUE cycle, MEM_LAT WAIT cycles and one WRITE cycle.
- Clear: done rises SCREEN_H+1 cycles after accept. There are exactly SCREEN_H write cycles.
- Draw with N=0: done rises 1 cycle after accept.
- A new request can be accepted in the cycle after done.
- Write data is registered. vram_data_out and vram_address_out are stable during every vram_write cycle.

## Configuration
- CHIP8_BLIT_WRAP_EN defined:
  - Columns x0+i ≥ SCREEN_W wrap to x0+i−SCREEN_W.
  - Rows y0+r ≥ SCREEN_H wrap to y0+r−SCREEN_H.
  - All N rows are always drawn.
- CHIP8_BLIT_WRAP_EN undefined (default, clip):
  - Off-screen columns are dropped from the mask.
  - The first off-screen row ends the draw; no RAM/VRAM access is made for it.

## Structure
- chip8_pkg holds:
  - op constants CHIP8_OP_DRAW=1'b0 and CHIP8_OP_CLEAR=1'b1;
  - the blitter state enum typedef;
  - default screen constants CHIP8_SCREEN_W=64 and CHIP8_SCREEN_H=32.
- The sub-module chip8_row_merge is combinational and parametrised on SCREEN_W. It takes old row, sprite byte and x0, and produces new row and a collide bit. It contains the wrap/clip mask logic under the same macro.

## Test plan
- Reset, clear with 64x32 and MEM_LAT=2 → 32 consecutive vram_write cycles for rows 0..31 with data 0; done at cycle 33; collision=0.
- Draw x=0, y=0, N=1, RAM[0x200]=0xF0 on an empty row → row 0 bits 0..3 set, collision=0, done at cycle 5. Repeating the same draw → row cleared, collision=1.
- Draw x=62, y=0, N=1, byte 0xFF:
  - clip → only bits 62,63 set;
  - WRAP_EN → bits 62,63,0..5 set.
- Draw x=0, y=30, N=4, 4 bytes 0x80:
  - clip → rows 30,31 written only, done after 2 rows;
  - WRAP_EN → rows 30,31,0,1 written.
- Draw with x=70, y=33 → treated as x=6, y=1. Draw with N=0 → done 1 cycle after accept, no memory writes.
- Assert reset during row 2 of an N=5 draw → vram_write low at the next edge, cmd_ready high after release. The next request executes normally.
